// File: rtl/t02_lcd1602_monitor.sv
// Receive-side mirror of an HD44780/LCD1602 write bus: decodes each transaction
// on the falling edge of lcd_en and keeps a copy of the two visible 16-char rows.
module t02_lcd1602_monitor (
  input  logic         clk,
  input  logic         rst,
  input  logic         lcd_en,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic [7:0]   lcd_data,
  output logic [127:0] row_1,
  output logic [127:0] row_2,
  output logic [6:0]   cursor,
  output logic         disp_on,
  output logic         ready,
  output logic         wr_pulse,
  output logic         err
);

  localparam logic [127:0] SPACES = {16{8'h20}};

  logic         en_s1_q, en_s2_q, en_s3_q, en_s1_d, en_s2_d, en_s3_d;
  logic         rs_s1_q, rs_s2_q, rs_s1_d, rs_s2_d;
  logic         rw_s1_q, rw_s2_q, rw_s1_d, rw_s2_d;
  logic [7:0]   data_s1_q, data_s2_q, data_s1_d, data_s2_d;
  logic [127:0] row1_q, row1_d, row2_q, row2_d;
  logic [6:0]   ac_q, ac_d;
  logic         id_q, id_d, cg_q, cg_d, disp_q, disp_d;
  logic         ready_q, ready_d, wr_q, wr_d, err_q, err_d;
  logic         fall;

  // DDRAM addresses that exist on a 2-line panel: 0x00-0x27 and 0x40-0x67.
  function automatic logic ac_valid(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) n = a + 7'd1;
    else     n = a - 7'd1;
    if (ac_valid(a)) begin
      if (inc && a == 7'h27)       n = 7'h40;
      else if (inc && a == 7'h67)  n = 7'h00;
      else if (!inc && a == 7'h00) n = 7'h67;
      else if (!inc && a == 7'h40) n = 7'h27;
    end
    return n;
  endfunction

  assign fall = !en_s2_q && en_s3_q;

  always_comb begin
    en_s1_d   = lcd_en;
    en_s2_d   = en_s1_q;
    en_s3_d   = en_s2_q;
    rs_s1_d   = lcd_rs;
    rs_s2_d   = rs_s1_q;
    rw_s1_d   = lcd_rw;
    rw_s2_d   = rw_s1_q;
    data_s1_d = lcd_data;
    data_s2_d = data_s1_q;
    row1_d    = row1_q;
    row2_d    = row2_q;
    ac_d      = ac_q;
    id_d      = id_q;
    cg_d      = cg_q;
    disp_d    = disp_q;
    ready_d   = ready_q;
    err_d     = err_q;
    wr_d      = 1'b0;

    if (fall) begin
      if (!ready_q) begin
        // Until the panel is initialised only a function set is honoured.
        if (!rs_s2_q && !rw_s2_q && data_s2_q[7:5] == 3'b001) ready_d = 1'b1;
      end else if (rw_s2_q) begin
        err_d = 1'b1;
      end else if (!rs_s2_q) begin
        casez (data_s2_q)
          8'b1???????: begin
            ac_d = data_s2_q[6:0];
            cg_d = 1'b0;
            if (!ac_valid(data_s2_q[6:0])) err_d = 1'b1;
          end
          8'b01??????: cg_d    = 1'b1;
          8'b001?????: ready_d = 1'b1;
          8'b0001????: ;
          8'b00001???: disp_d  = data_s2_q[2];
          8'b000001??: id_d    = data_s2_q[1];
          8'b0000001?: begin
            ac_d = 7'h00;
            cg_d = 1'b0;
          end
          8'b00000001: begin
            row1_d = SPACES;
            row2_d = SPACES;
            ac_d   = 7'h00;
            id_d   = 1'b1;
            cg_d   = 1'b0;
          end
          default: ;
        endcase
      end else if (!cg_q) begin
        // Column c sits at bits [8*(15-c)+7 : 8*(15-c)]; 15-c is ~c in 4 bits.
        if (ac_q[6:4] == 3'b000) begin
          row1_d[{~ac_q[3:0], 3'b000} +: 8] = data_s2_q;
          wr_d = 1'b1;
        end else if (ac_q[6:4] == 3'b100) begin
          row2_d[{~ac_q[3:0], 3'b000} +: 8] = data_s2_q;
          wr_d = 1'b1;
        end else if (!ac_valid(ac_q)) begin
          err_d = 1'b1;
        end
        ac_d = ac_step(ac_q, id_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
      en_s3_q   <= 1'b0;
      rs_s1_q   <= 1'b0;
      rs_s2_q   <= 1'b0;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
      data_s1_q <= 8'h00;
      data_s2_q <= 8'h00;
      row1_q    <= SPACES;
      row2_q    <= SPACES;
      ac_q      <= 7'h00;
      id_q      <= 1'b1;
      cg_q      <= 1'b0;
      disp_q    <= 1'b0;
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      en_s1_q   <= en_s1_d;
      en_s2_q   <= en_s2_d;
      en_s3_q   <= en_s3_d;
      rs_s1_q   <= rs_s1_d;
      rs_s2_q   <= rs_s2_d;
      rw_s1_q   <= rw_s1_d;
      rw_s2_q   <= rw_s2_d;
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
      row1_q    <= row1_d;
      row2_q    <= row2_d;
      ac_q      <= ac_d;
      id_q      <= id_d;
      cg_q      <= cg_d;
      disp_q    <= disp_d;
      ready_q   <= ready_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
    end
  end

  assign row_1    = row1_q;
  assign row_2    = row2_q;
  assign cursor   = ac_q;
  assign disp_on  = disp_q;
  assign ready    = ready_q;
  assign wr_pulse = wr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_t02_lcd1602_monitor.sv
// Bench for t02_lcd1602_monitor: drives LCD bus transactions, keeps a reference
// model of the panel, and matches every wr_pulse against an expected-write queue.
module tb_t02_lcd1602_monitor;

  localparam logic [127:0] SPACES = {16{8'h20}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0]   lcd_data = 8'h00;
  logic [127:0] row_1, row_2;
  logic [6:0]   cursor;
  logic         disp_on, ready, wr_pulse, err;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;

  // Expected write: {row select, column, byte}
  logic [12:0] exp_q[$];

  logic [7:0] m_row [2][16];
  logic [6:0] m_ac;
  logic       m_id, m_cg, m_disp, m_ready, m_err;

  t02_lcd1602_monitor dut (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .row_1(row_1), .row_2(row_2), .cursor(cursor),
    .disp_on(disp_on), .ready(ready), .wr_pulse(wr_pulse), .err(err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] m_pack(input int r);
    logic [127:0] v;
    for (int c = 0; c < 16; c++) v[(15 - c) * 8 +: 8] = m_row[r][c];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) m_row[r][c] = 8'h20;
    m_ac = 0; m_id = 1; m_cg = 0; m_disp = 0; m_ready = 0; m_err = 0;
  endtask

  function automatic bit in_map(input logic [6:0] a);
    return (a < 7'h28) || (a >= 7'h40 && a < 7'h68);
  endfunction

  task automatic model_step(input logic rs, input logic rw, input logic [7:0] d);
    if (!m_ready) begin
      if (!rs && !rw && d[7:5] == 3'b001) m_ready = 1;
      return;
    end
    if (rw) begin
      m_err = 1;
      return;
    end
    if (!rs) begin
      if (d[7]) begin
        m_ac = d[6:0]; m_cg = 0;
        if (!in_map(d[6:0])) m_err = 1;
      end
      else if (d[6]) m_cg = 1;
      else if (d[5]) m_ready = 1;
      else if (d[4]) ;
      else if (d[3]) m_disp = d[2];
      else if (d[2]) m_id = d[1];
      else if (d[1]) begin m_ac = 0; m_cg = 0; end
      else if (d[0]) begin
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 16; c++) m_row[r][c] = 8'h20;
        m_ac = 0; m_id = 1; m_cg = 0;
      end
      return;
    end
    if (m_cg) return;
    if (m_ac < 16) begin
      m_row[0][m_ac] = d;
      exp_q.push_back({1'b0, m_ac[3:0], d});
    end else if (m_ac >= 7'h40 && m_ac < 7'h50) begin
      m_row[1][m_ac - 7'h40] = d;
      exp_q.push_back({1'b1, m_ac[3:0], d});
    end else if (!in_map(m_ac)) m_err = 1;
    if (m_id) begin
      if (m_ac == 7'h27) m_ac = 7'h40;
      else if (m_ac == 7'h67) m_ac = 7'h00;
      else m_ac = m_ac + 1;
    end else begin
      if (m_ac == 7'h00) m_ac = 7'h67;
      else if (m_ac == 7'h40) m_ac = 7'h27;
      else m_ac = m_ac - 1;
    end
  endtask

  task automatic model_compare(input string tag);
    check_eq({tag, "_row1"},   row_1,   m_pack(0));
    check_eq({tag, "_row2"},   row_2,   m_pack(1));
    check_eq({tag, "_cursor"}, cursor,  m_ac);
    check_eq({tag, "_disp"},   disp_on, m_disp);
    check_eq({tag, "_ready"},  ready,   m_ready);
    check_eq({tag, "_err"},    err,     m_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk); rst = 1'b0; lcd_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  // One bus cycle: 3 clocks setup, 3 clocks enable high, 4 clocks hold/settle.
  // With kill set, rst is pulsed while the falling edge is still in the synchronizer.
  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d, input bit kill);
    @(negedge clk); lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b0;
    repeat (3) @(negedge clk);
    lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
    if (kill) begin
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      model_reset();
      exp_q.delete();
    end else begin
      model_step(rs, rw, d);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);
    bus_xfer(1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic dat(input logic [7:0] d);
    bus_xfer(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic write_str(input logic [127:0] s, input int n);
    for (int c = 0; c < n; c++) dat(s[(15 - c) * 8 +: 8]);
  endtask

  task automatic refresh(input logic [127:0] r1, input logic [127:0] r2);
    cmd(8'h38); cmd(8'h0C); cmd(8'h06);
    cmd(8'h80); write_str(r1, 16);
    cmd(8'hC0); write_str(r2, 16);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst && wr_pulse) begin
      logic [12:0]  e;
      logic [127:0] r;
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("pulse_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        r = e[12] ? row_2 : row_1;
        check_eq("pulse_byte", r[(15 - int'(e[11:8])) * 8 +: 8], e[7:0]);
      end
    end
  end

  // ---------------- test sequence ----------------
  int p0;
  logic [127:0] s1, s2;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_row1", row_1, SPACES);
    check_eq("rst_row2", row_2, SPACES);
    check_eq("rst_cursor", cursor, 7'h00);
    check_eq("rst_flags", {disp_on, ready, wr_pulse, err}, 4'b0000);

    // Pre-init: everything but a function set is ignored.
    dat(8'h41); cmd(8'h0C);
    check_eq("preinit_row1", row_1, SPACES);
    check_eq("preinit_disp", disp_on, 1'b0);
    check_eq("preinit_err", err, 1'b0);
    check_eq("preinit_ready", ready, 1'b0);

    // Init, then a full row of data.
    p0 = pulse_cnt;
    cmd(8'h38); cmd(8'h08); cmd(8'h01); cmd(8'h06); cmd(8'h0C);
    cmd(8'h80); write_str("HELLO WORLD 1234", 16);
    check_eq("hello_ready", ready, 1'b1);
    check_eq("hello_disp", disp_on, 1'b1);
    check_eq("hello_row1", row_1, "HELLO WORLD 1234");
    check_eq("hello_row2", row_2, SPACES);
    check_eq("hello_cursor", cursor, 7'h10);
    check_eq("hello_pulses", pulse_cnt - p0, 16);
    model_compare("hello");

    // Clear wipes the mirror and homes AC without any pulse.
    p0 = pulse_cnt;
    cmd(8'h01);
    check_eq("clear_row1", row_1, SPACES);
    check_eq("clear_cursor", cursor, 7'h00);
    check_eq("clear_pulses", pulse_cnt - p0, 0);

    // Line wrap at the ends of both lines.
    do_reset();
    p0 = pulse_cnt;
    cmd(8'h38); cmd(8'hA7); dat("A");
    check_eq("wrap_27_40", cursor, 7'h40);
    cmd(8'hE7); dat("B");
    check_eq("wrap_67_00", cursor, 7'h00);
    check_eq("wrap_pulses", pulse_cnt - p0, 0);
    check_eq("wrap_row1", row_1, SPACES);
    check_eq("wrap_row2", row_2, SPACES);

    // Decrement mode across the line-2 start.
    do_reset();
    cmd(8'h38); cmd(8'h04); cmd(8'hC0); dat("X");
    check_eq("dec_row2", row_2, {"X", {15{8'h20}}});
    check_eq("dec_cursor", cursor, 7'h27);

    // CGRAM discard, invalid DDRAM address, read cycle, write at invalid AC.
    do_reset();
    cmd(8'h38); cmd(8'h40); dat(8'hFF);
    check_eq("cg_row1", row_1, SPACES);
    check_eq("cg_cursor", cursor, 7'h00);
    check_eq("cg_err", err, 1'b0);
    cmd(8'hB0);
    check_eq("bad_addr_err", err, 1'b1);
    check_eq("bad_addr_cursor", cursor, 7'h30);
    bus_xfer(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("read_err", err, 1'b1);
    check_eq("read_cursor", cursor, 7'h30);
    p0 = pulse_cnt;
    dat(8'h5A);
    check_eq("bad_wr_cursor", cursor, 7'h31);
    check_eq("bad_wr_pulses", pulse_cnt - p0, 0);
    model_compare("errs");

    // Reset while a fall is in the synchronizer drops that transaction.
    do_reset();
    bus_xfer(1'b0, 1'b0, 8'h38, 1'b1);
    check_eq("kill_ready", ready, 1'b0);
    cmd(8'h38);
    check_eq("after_kill_ready", ready, 1'b1);

    // End-to-end refresh with a mid-refresh reset.
    s1 = "0123456789ABCDEF";
    s2 = "fedcba9876543210";
    do_reset();
    refresh(s1, s2);
    check_eq("e2e_row1", row_1, s1);
    check_eq("e2e_row2", row_2, s2);
    cmd(8'h38); cmd(8'h80); write_str(s2, 8);
    do_reset();
    check_eq("e2e_rst_row1", row_1, SPACES);
    check_eq("e2e_rst_row2", row_2, SPACES);
    refresh(s1, s2);
    check_eq("e2e_again_row1", row_1, s1);
    check_eq("e2e_again_row2", row_2, s2);

    // Random mix against the model.
    do_reset();
    cmd(8'h38); cmd(8'h0C); cmd(8'h06);
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 12);
      if (op <= 6)       dat(8'($urandom_range(8'h21, 8'h7E)));
      else if (op == 7)  cmd({1'b1, 7'($urandom_range(0, 127))});
      else if (op == 8)  cmd({1'b1, 3'b100, 4'($urandom_range(0, 15))});
      else if (op == 9)  cmd({1'b1, 3'b000, 4'($urandom_range(0, 15))});
      else if (op == 10) cmd({6'b000001, 1'($urandom_range(0, 1)), 1'b0});
      else if (op == 11) cmd(8'h02);
      else               cmd({5'b00001, 1'($urandom_range(0, 1)), 2'b00});
      model_compare("rand");
    end

    repeat (4) @(negedge clk);
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
